ifu_bpu: RTL



---
 rtl/ifu_bpu_pkg.sv | 39 +++
 rtl/ifu_bpu_if.sv | 27 ++
 rtl/ifu_ras.sv | 65 ++++++
 rtl/ifu_bpu.sv | 119 +++++++++++
 4 files changed

// File: rtl/ifu_bpu_pkg.sv
// Shared constants, types and immediate helpers for the IFU branch-prediction unit.
// Decode constants and the BHT counter width live here so decode and the tests agree.
package ifu_bpu_pkg;

    localparam int unsigned PC_SIZE    = 32;
    localparam int unsigned INSTR_SIZE = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    localparam int unsigned            BHT_CNT_W = 2;
    localparam logic [BHT_CNT_W-1:0]   BHT_INIT  = BHT_CNT_W'(1);

    typedef enum logic [1:0] {RasNone, RasPush, RasPop, RasPopPush} ras_op_e;

    typedef struct packed {
        logic               valid;
        logic               is_bjp;
        logic               taken;
        logic [PC_SIZE-1:0] pc;
    } prdt_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

    function automatic logic [PC_SIZE-1:0] imm_j(input logic [INSTR_SIZE-1:0] instr);
        return {{(PC_SIZE-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [PC_SIZE-1:0] imm_b(input logic [INSTR_SIZE-1:0] instr);
        return {{(PC_SIZE-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_bpu_if.sv
// Fetch-side, resolve-side and prediction signals of the branch-prediction unit.
interface ifu_bpu_if;
    import ifu_bpu_pkg::*;

    logic                  i_valid;
    logic [PC_SIZE-1:0]    i_pc;
    logic [INSTR_SIZE-1:0] i_instr;
    logic                  flush;
    logic                  upd_valid;
    logic [PC_SIZE-1:0]    upd_pc;
    logic                  upd_taken;
    logic                  o_prdt_valid;
    logic                  o_is_bjp;
    logic                  o_prdt_taken;
    logic [PC_SIZE-1:0]    o_prdt_pc;

    modport master (
        output i_valid, i_pc, i_instr, flush, upd_valid, upd_pc, upd_taken,
        input  o_prdt_valid, o_is_bjp, o_prdt_taken, o_prdt_pc
    );

    modport slave (
        input  i_valid, i_pc, i_instr, flush, upd_valid, upd_pc, upd_taken,
        output o_prdt_valid, o_is_bjp, o_prdt_taken, o_prdt_pc
    );

endinterface

// File: rtl/ifu_ras.sv
// Circular return-address stack: overflow drops the oldest entry, underflow is ignored.
module ifu_ras
    import ifu_bpu_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [PC_SIZE-1:0] push_data,
    input  logic               clear,
    output logic [PC_SIZE-1:0] top,
    output logic               empty
);
    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(RAS_DEPTH - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

    logic [PC_SIZE-1:0] stack_q [RAS_DEPTH];
    logic [PtrW-1:0]    ptr_q, ptr_d, ptr_inc, top_idx, wr_idx;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               wr_en;

    // ptr_q is the next free slot; the top entry sits one below it.
    assign ptr_inc = (ptr_q == PtrMax) ? '0 : ptr_q + PtrW'(1);
    assign top_idx = (ptr_q == '0) ? PtrMax : ptr_q - PtrW'(1);
    assign top     = stack_q[top_idx];
    assign empty   = (cnt_q == '0);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (clear) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_inc;
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) stack_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_bpu.sv
// IFU branch-prediction unit: decodes branch/JAL/JALR, predicts with static or bimodal BHT
// and a return-address stack, and registers the prediction for the next-PC mux.
module ifu_bpu
    import ifu_bpu_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned RAS_DEPTH   = 4,
    parameter int unsigned PRED_MODE   = 1
) (
    input logic      clk,
    input logic      rst,
    ifu_bpu_if.slave bus
);
    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    logic [BHT_CNT_W-1:0] bht_q [BHT_ENTRIES];
    logic [IdxW-1:0]      prd_idx, upd_idx;
    logic [BHT_CNT_W-1:0] upd_cnt, upd_cnt_next;
    logic [4:0]           rd, rs1;
    logic                 rd_link, rs1_link;
    logic [PC_SIZE-1:0]   pc_inc, br_imm, ras_top;
    logic                 ras_empty, ras_push, ras_pop;
    ras_op_e              ras_op;
    prdt_t                prdt_d, prdt_q;
    logic                 unused_upd_pc;

    assign prd_idx       = bus.i_pc[IdxW+1:2];
    assign upd_idx       = bus.upd_pc[IdxW+1:2];
    assign unused_upd_pc = ^{bus.upd_pc[PC_SIZE-1:IdxW+2], bus.upd_pc[1:0]};
    assign rd            = bus.i_instr[11:7];
    assign rs1           = bus.i_instr[19:15];
    assign rd_link       = is_link(rd);
    assign rs1_link      = is_link(rs1);
    assign pc_inc        = bus.i_pc + PC_SIZE'(4);
    assign br_imm        = imm_b(bus.i_instr);
    assign upd_cnt       = bht_q[upd_idx];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (bus.upd_taken) begin
            if (upd_cnt != '1) upd_cnt_next = upd_cnt + BHT_CNT_W'(1);
        end else if (upd_cnt != '0) begin
            upd_cnt_next = upd_cnt - BHT_CNT_W'(1);
        end
    end

    // Prediction reads bht_q, so a same-cycle update to the same index is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_INIT;
        end else if (bus.upd_valid) begin
            bht_q[upd_idx] <= upd_cnt_next;
        end
    end

    always_comb begin
        prdt_d = '0;
        ras_op = RasNone;
        if (bus.i_valid && !bus.flush) begin
            prdt_d.valid = 1'b1;
            prdt_d.pc    = pc_inc;
            case (bus.i_instr[6:0])
                OPC_JAL: begin
                    prdt_d.is_bjp = 1'b1;
                    prdt_d.taken  = 1'b1;
                    prdt_d.pc     = bus.i_pc + imm_j(bus.i_instr);
                    if (rd_link) ras_op = RasPush;
                end
                OPC_JALR: begin
                    prdt_d.is_bjp = 1'b1;
                    // Return hint: pop, or pop+push for a coroutine swap (rd != rs1).
                    if (rs1_link && !(rd_link && (rd == rs1))) begin
                        ras_op = rd_link ? RasPopPush : RasPop;
                        if (!ras_empty) begin
                            prdt_d.taken = 1'b1;
                            prdt_d.pc    = ras_top;
                        end
                    end else if (rd_link) begin
                        ras_op = RasPush;
                    end
                end
                OPC_BRANCH: begin
                    prdt_d.is_bjp = 1'b1;
                    prdt_d.taken  = (PRED_MODE == 0) ? br_imm[PC_SIZE-1]
                                                     : bht_q[prd_idx][BHT_CNT_W-1];
                    if (prdt_d.taken) prdt_d.pc = bus.i_pc + br_imm;
                end
                default: ;
            endcase
        end
    end

    assign ras_push = (ras_op == RasPush) || (ras_op == RasPopPush);
    assign ras_pop  = (ras_op == RasPop) || (ras_op == RasPopPush);

    ifu_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .clear     (bus.flush),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prdt_q <= '0;
        else     prdt_q <= prdt_d;
    end

    assign bus.o_prdt_valid = prdt_q.valid;
    assign bus.o_is_bjp     = prdt_q.is_bjp;
    assign bus.o_prdt_taken = prdt_q.taken;
    assign bus.o_prdt_pc    = prdt_q.pc;

endmodule
